// File: rtl/idma_pkg.sv
// Shared types and constants for the iDMA read-address arbitration path.
package idma_pkg;

    localparam int NUM_REQ_DEF = 3;

    localparam int SRC_NORM = 0;
    localparam int SRC_RESI = 1;
    localparam int SRC_WT   = 2;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_e;

endpackage

// File: rtl/idma_rr_pick.sv
// Round-robin winner select: first valid requester after i_rr_ptr, wrapping.
module idma_rr_pick
    import idma_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDW-1:0]     i_rr_ptr,
    output logic [IDW-1:0]     o_winner,
    output logic               o_any_valid
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        // Scan starts one past the pointer, so the last owner is checked last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = int'(i_rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && i_valid[w_idx]) begin
                o_winner = IDW'(w_idx);
                w_found  = 1'b1;
            end
        end
    end

    assign o_any_valid = |i_valid;

endmodule

// File: rtl/idma_rd_addr_arb.sv
// Round-robin, burst-locked arbiter sharing the read-address FIFO between
// the address generators; each pushed address carries its source ID.
//
//  state    | meaning
//  ARB_IDLE | no grant held; pick next owner if any requester is valid
//  ARB_LOCK | owner holds the FIFO until it pushes a beat flagged last
module idma_rd_addr_arb
    import idma_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int AW      = 32,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  cclk,
    input  logic                  rst_n,
    input  logic                  i_arb_clr,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    input  logic [NUM_REQ*AW-1:0] i_req_addr,
    input  logic [NUM_REQ-1:0]    i_req_last,
    output logic [NUM_REQ-1:0]    o_req_ready,
    input  logic                  i_rd_afifo_full_s,
    output logic                  o_afifo_push,
    output logic [AW-1:0]         o_afifo_addr,
    output logic [IDW-1:0]        o_afifo_src,
    output logic                  o_arb_busy,
    output logic [15:0]           o_beat_cnt
);

    arb_state_e     r_state;
    arb_state_e     w_state_nxt;
    logic [IDW-1:0] r_owner;
    logic [IDW-1:0] w_owner_nxt;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] w_rr_nxt;
    logic [15:0]    r_beat_cnt;
    logic [15:0]    w_cnt_nxt;
    logic [IDW-1:0] w_pick;
    logic           w_any;
    logic           w_lock;
    logic           w_beat;

    idma_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .i_valid     (i_req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_winner    (w_pick),
        .o_any_valid (w_any)
    );

    always_comb begin
        w_lock       = (r_state == ARB_LOCK);
        // An abort cycle accepts nothing, so no half-dropped beat reaches the FIFO.
        w_beat       = w_lock && !i_arb_clr && i_req_valid[r_owner] && !i_rd_afifo_full_s;
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_nxt     = r_rr_ptr;
        w_cnt_nxt    = r_beat_cnt;
        o_req_ready  = '0;
        o_afifo_addr = '0;

        if (w_beat) begin
            o_req_ready[r_owner] = 1'b1;
            o_afifo_addr         = i_req_addr[int'(r_owner)*AW +: AW];
        end

        case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ARB_LOCK;
                    w_owner_nxt = w_pick;
                end
            end
            ARB_LOCK: begin
                if (w_beat) begin
                    if (i_req_last[r_owner]) begin
                        w_state_nxt = ARB_IDLE;
                        w_rr_nxt    = r_owner;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_beat_cnt + 16'd1;
                    end
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase

        if (i_arb_clr) begin
            w_state_nxt = ARB_IDLE;
            w_owner_nxt = '0;
            w_rr_nxt    = IDW'(NUM_REQ-1);
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= IDW'(NUM_REQ-1);
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_beat_cnt <= w_cnt_nxt;
        end
    end

    assign o_afifo_push = w_beat;
    assign o_afifo_src  = w_lock ? r_owner : '0;
    assign o_arb_busy   = w_lock;
    assign o_beat_cnt   = r_beat_cnt;

endmodule

// File: tb/tb_idma_rd_addr_arb.sv
// Directed bench for idma_rd_addr_arb: vector table plus hand-written corner sequences.
module tb_idma_rd_addr_arb;

    logic        cclk;
    logic        rst_n;
    logic        arb_clr;
    logic [2:0]  req_valid;
    logic [31:0] a0, a1, a2;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic        full_s;
    logic        afifo_push;
    logic [31:0] afifo_addr;
    logic [1:0]  afifo_src;
    logic        arb_busy;
    logic [15:0] beat_cnt;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  last;
        logic        full;
        logic        rst;
        logic [31:0] x0, x1, x2;
        logic [2:0]  e_ready;
        logic        e_push;
        logic [31:0] e_addr;
        logic [1:0]  e_src;
        logic        e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    idma_rd_addr_arb dut (
        .cclk              (cclk),
        .rst_n             (rst_n),
        .i_arb_clr         (arb_clr),
        .i_req_valid       (req_valid),
        .i_req_addr        ({a2, a1, a0}),
        .i_req_last        (req_last),
        .o_req_ready       (req_ready),
        .i_rd_afifo_full_s (full_s),
        .o_afifo_push      (afifo_push),
        .o_afifo_addr      (afifo_addr),
        .o_afifo_src       (afifo_src),
        .o_arb_busy        (arb_busy),
        .o_beat_cnt        (beat_cnt)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    task automatic add(input logic [2:0] v, input logic [2:0] l, input logic f, input logic r,
                       input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2,
                       input logic [2:0] er, input logic ep, input logic [31:0] ea,
                       input logic [1:0] es, input logic eb, input logic [15:0] ec);
        vec_t t;
        t.valid = v; t.last = l; t.full = f; t.rst = r;
        t.x0 = x0; t.x1 = x1; t.x2 = x2;
        t.e_ready = er; t.e_push = ep; t.e_addr = ea;
        t.e_src = es; t.e_busy = eb; t.e_cnt = ec;
        tbl.push_back(t);
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] er, input logic ep,
                       input logic [31:0] ea, input logic [1:0] es, input logic eb,
                       input logic [15:0] ec);
        cmp({tag, "_ready"}, 32'(req_ready), 32'(er));
        cmp({tag, "_push"},  32'(afifo_push), 32'(ep));
        cmp({tag, "_addr"},  afifo_addr, ea);
        cmp({tag, "_src"},   32'(afifo_src), 32'(es));
        cmp({tag, "_busy"},  32'(arb_busy), 32'(eb));
        cmp({tag, "_cnt"},   32'(beat_cnt), 32'(ec));
    endtask

    task automatic set_in(input logic [2:0] v, input logic [2:0] l, input logic f, input logic c,
                          input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2);
        req_valid = v; req_last = l; full_s = f; arb_clr = c;
        a0 = x0; a1 = x1; a2 = x2;
    endtask

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        // test 1: req1 four-beat burst
        add(3'b010, 3'b000, 0, 0, 0, 32'h1000, 0, 3'b000, 0, 0,        0, 0, 0);
        add(3'b010, 3'b000, 0, 0, 0, 32'h1000, 0, 3'b010, 1, 32'h1000, 1, 1, 0);
        add(3'b010, 3'b000, 0, 0, 0, 32'h1040, 0, 3'b010, 1, 32'h1040, 1, 1, 1);
        add(3'b010, 3'b000, 0, 0, 0, 32'h1080, 0, 3'b010, 1, 32'h1080, 1, 1, 2);
        add(3'b010, 3'b010, 0, 0, 0, 32'h10C0, 0, 3'b010, 1, 32'h10C0, 1, 1, 3);
        add(3'b000, 3'b000, 0, 0, 0, 0,        0, 3'b000, 0, 0,        0, 0, 0);
        // test 2: all valid from reset, order 0,1,2,0 with IDLE bubbles
        add(3'b111, 3'b000, 0, 1, 32'h2000, 32'h3000, 32'h4000, 3'b000, 0, 0,        0, 0, 0);
        add(3'b111, 3'b000, 0, 0, 32'h2000, 32'h3000, 32'h4000, 3'b001, 1, 32'h2000, 0, 1, 0);
        add(3'b111, 3'b001, 0, 0, 32'h2004, 32'h3000, 32'h4000, 3'b001, 1, 32'h2004, 0, 1, 1);
        add(3'b111, 3'b000, 0, 0, 32'h2008, 32'h3000, 32'h4000, 3'b000, 0, 0,        0, 0, 0);
        add(3'b111, 3'b001, 0, 0, 32'h2008, 32'h3000, 32'h4000, 3'b010, 1, 32'h3000, 1, 1, 0);
        add(3'b111, 3'b010, 0, 0, 32'h2008, 32'h3004, 32'h4000, 3'b010, 1, 32'h3004, 1, 1, 1);
        add(3'b111, 3'b000, 0, 0, 32'h2008, 32'h3008, 32'h4000, 3'b000, 0, 0,        0, 0, 0);
        add(3'b111, 3'b000, 0, 0, 32'h2008, 32'h3008, 32'h4000, 3'b100, 1, 32'h4000, 2, 1, 0);
        add(3'b111, 3'b100, 0, 0, 32'h2008, 32'h3008, 32'h4004, 3'b100, 1, 32'h4004, 2, 1, 1);
        add(3'b011, 3'b000, 0, 0, 32'h2008, 32'h3008, 0,        3'b000, 0, 0,        0, 0, 0);
        add(3'b011, 3'b000, 0, 0, 32'h2008, 32'h3008, 0,        3'b001, 1, 32'h2008, 0, 1, 0);
        add(3'b011, 3'b001, 0, 0, 32'h200C, 32'h3008, 0,        3'b001, 1, 32'h200C, 0, 1, 1);
        // test 3: FIFO full for 5 cycles on req1's last beat
        add(3'b010, 3'b000, 0, 0, 0, 32'h3008, 0, 3'b000, 0, 0,        0, 0, 0);
        add(3'b010, 3'b000, 0, 0, 0, 32'h3008, 0, 3'b010, 1, 32'h3008, 1, 1, 0);
        for (int i = 0; i < 5; i++)
            add(3'b010, 3'b010, 1, 0, 0, 32'h300C, 0, 3'b000, 0, 0, 1, 1, 1);
        add(3'b010, 3'b010, 0, 0, 0, 32'h300C, 0, 3'b010, 1, 32'h300C, 1, 1, 1);
        add(3'b000, 3'b000, 0, 0, 0, 0,        0, 3'b000, 0, 0,        0, 0, 0);

        set_in(3'b111, 3'b111, 0, 0, 32'hA, 32'hB, 32'hC);
        rst_n = 1'b0;
        #3;
        chk("reset", 3'b000, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            set_in(tbl[i].valid, tbl[i].last, tbl[i].full, 1'b0, tbl[i].x0, tbl[i].x1, tbl[i].x2);
            #1;
            chk($sformatf("row%0d", i), tbl[i].e_ready, tbl[i].e_push, tbl[i].e_addr,
                tbl[i].e_src, tbl[i].e_busy, tbl[i].e_cnt);
            tick();
        end

        // test 4: owner drops valid while req2 waits
        do_reset();
        set_in(3'b001, 3'b000, 0, 0, 32'h5000, 0, 32'h6000);
        #1; chk("t4_idle", 3'b000, 0, 0, 0, 0, 0); tick();
        #1; chk("t4_b1", 3'b001, 1, 32'h5000, 0, 1, 0); tick();
        for (int i = 0; i < 3; i++) begin
            set_in(3'b100, 3'b000, 0, 0, 32'h5004, 0, 32'h6000);
            #1; chk($sformatf("t4_gap%0d", i), 3'b000, 0, 0, 0, 1, 1); tick();
        end
        set_in(3'b101, 3'b001, 0, 0, 32'h5004, 0, 32'h6000);
        #1; chk("t4_last", 3'b001, 1, 32'h5004, 0, 1, 1); tick();
        set_in(3'b100, 3'b000, 0, 0, 0, 0, 32'h6000);
        #1; chk("t4_bubble", 3'b000, 0, 0, 0, 0, 0); tick();
        set_in(3'b100, 3'b100, 0, 0, 0, 0, 32'h6000);
        #1; chk("t4_req2", 3'b100, 1, 32'h6000, 2, 1, 0); tick();

        // test 5: single-beat burst, then arb_clr mid-burst
        do_reset();
        set_in(3'b001, 3'b001, 0, 0, 32'h7000, 0, 0);
        #1; chk("t5_idle", 3'b000, 0, 0, 0, 0, 0); tick();
        #1; chk("t5_single", 3'b001, 1, 32'h7000, 0, 1, 0); tick();
        set_in(3'b000, 3'b000, 0, 0, 0, 0, 0);
        #1; chk("t5_done", 3'b000, 0, 0, 0, 0, 0); tick();
        set_in(3'b010, 3'b000, 0, 0, 0, 32'h8000, 0);
        #1; chk("t5_idle2", 3'b000, 0, 0, 0, 0, 0); tick();
        #1; chk("t5_b1", 3'b010, 1, 32'h8000, 1, 1, 0); tick();
        set_in(3'b010, 3'b000, 0, 0, 0, 32'h8040, 0);
        #1; chk("t5_b2", 3'b010, 1, 32'h8040, 1, 1, 1); tick();
        set_in(3'b010, 3'b000, 0, 1, 0, 32'h8080, 0);
        #1; chk("t5_clr", 3'b000, 0, 0, 1, 1, 2); tick();
        set_in(3'b011, 3'b000, 0, 0, 32'h9000, 32'h8080, 0);
        #1; chk("t5_post", 3'b000, 0, 0, 0, 0, 0); tick();
        #1; chk("t5_rr", 3'b001, 1, 32'h9000, 0, 1, 0); tick();

        // test 6: async reset while locked
        set_in(3'b011, 3'b000, 0, 0, 32'h9040, 32'h8080, 0);
        #1; chk("t6_pre", 3'b001, 1, 32'h9040, 0, 1, 1);
        rst_n = 1'b0;
        #1; chk("t6_rst", 3'b000, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1; chk("t6_idle", 3'b000, 0, 0, 0, 0, 0); tick();
        #1; chk("t6_rr", 3'b001, 1, 32'h9040, 0, 1, 0); tick();
        set_in(3'b000, 3'b000, 0, 0, 0, 0, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
